pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the core's fetch path: holds the architectural PC and advances it on each step request. Sits directly downstream of the clocked 32-bit offset adder. It drives that adder's operands for taken branches and jumps, and consumes its registered sum one cycle later. It alignment-checks the target and loads it into the PC, or raises a fault. Sequential and not-taken steps use an internal +4 incrementer and bypass the adder.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  step request present.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_op  in  2  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR.
- req_taken  in  1  branch outcome; ignored unless req_op is BRANCH.
- req_offset  in  32  sign-extended immediate.
- req_base  in  32  rs1 value; used only for JALR.
- add_a  out  32  adder operand A (registered).
- add_b  out  32  adder operand B (registered).
- add_sum  in  32  registered sum from the offset adder.
- pc  out  32  current PC.
- link  out  32  old PC + 4, captured at acceptance.
- done  out  1  one-cycle pulse: the step has completed.
- fault  out  1  one-cycle pulse: misaligned target (coincides with done).
- fault_addr  out  32  offending target; valid while fault is high.

## Operation
- States:
  - IDLE: req_ready=1.
  - WAIT: operands presented to the adder.
  - LOAD: add_sum valid.
- Acceptance is req_valid && req_ready at a rising edge.
- IDLE, SEQ or not-taken BRANCH accepted:
  - pc <= pc+4, link <= pc+4, done <= 1.
  - State stays IDLE.
- IDLE, taken BRANCH, JAL or JALR accepted:
  - add_a <= (JALR ? req_base : pc), add_b <= req_offset.
  - link <= pc+4.
  - Transition to WAIT.
- WAIT: the adder captures its sum at this edge; transition to LOAD unconditionally.
- LOAD:
  - target = add_sum, with bit 0 cleared for JALR.
  - Aligned target: pc <= target, done <= 1.
  - Misaligned target: pc unchanged, done <= 1, fault <= 1, fault_addr <= target.
  - Transition to IDLE.
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC steps to 32'h0000_0000. The adder sum wraps the same way.
- add_a and add_b hold their values outside acceptance; no other block relies on them outside WAIT/LOAD.
- Requests presented while req_ready=0 are not consumed; the requester holds them stable.
- Reset, asynchronous, any state including mid-WAIT/LOAD:
  - state=IDLE, pc=RESET_PC.
  - link=0, add_a=0, add_b=0.
  - done=0, fault=0, fault_addr=0.
  - An in-flight target is discarded.

## Timing
- SEQ/not-taken: new pc and done are visible the cycle after acceptance (latency 1).
- Taken/JAL/JALR, with acceptance at edge E0:
  - E1: adder captures the sum.
  - E2: pc loads; done (and fault) pulse in the cycle after E2 (latency 2).
- req_ready returns high in the same cycle done pulses, so back-to-back requests are allowed. Sustained throughput is one SEQ step per cycle, or one jump per 3 cycles.
- done and fault are single-cycle pulses, never high for two consecutive cycles from one request.

## Configuration
- RVC_ALIGN_EN defined: targets need only 2-byte alignment; fault iff target[0]=1. For JALR this never faults, since bit 0 is cleared.
- RVC_ALIGN_EN undefined: targets need 4-byte alignment; fault iff target[1:0]!=0.
- The sequential increment is +4 in both configurations.

## Structure
- Shared package pc_seq_pkg holds:
  - op enum (OP_SEQ, OP_BRANCH, OP_JAL, OP_JALR).
  - state enum (ST_IDLE, ST_WAIT, ST_LOAD).
  - the default RESET_PC constant.
- One sub-module, target_align_check: combinational; target in, misaligned flag out. It is the only place RVC_ALIGN_EN is tested.

## Test plan
- Reset released, then SEQ ×3 -> pc 0→4→8→C; done pulses each cycle after acceptance; link 4, 8, C.
- pc=0x100, BRANCH taken, offset 0xFFFF_FFF0 -> add_a=0x100, add_b=0xFFFF_FFF0; two cycles later pc=0xF0, done=1, fault=0.
- pc=0x200, JALR, base 0x1003, offset 4:
  - RVC_ALIGN_EN undefined -> target 0x1006, fault=1, fault_addr=0x1006, pc stays 0x200, link=0x204.
  - RVC_ALIGN_EN defined -> pc=0x1006, no fault.
- pc=0xFFFF_FFFC, SEQ -> pc=0x0000_0000; BRANCH with req_taken=0 -> pc+4; adder operands unchanged.
- JAL accepted, reset_n asserted in WAIT -> immediately pc=RESET_PC, state IDLE, done=0; after release the next SEQ yields RESET_PC+4.
- req_valid held high throughout a JAL -> req_ready low for WAIT/LOAD; the second request is accepted in the done cycle, not before.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'd0,
        OP_BRANCH = 2'd1,
        OP_JAL    = 2'd2,
        OP_JALR   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/target_align_check.sv
// Combinational alignment check of a jump/branch target.
// RVC_ALIGN_EN defined: 2-byte alignment; otherwise 4-byte alignment.
module target_align_check (
    input  logic [31:0] target,
    output logic        misaligned
);

`ifdef RVC_ALIGN_EN
    logic unused_hi;
    assign unused_hi  = ^target[31:1];
    assign misaligned = target[0];
`else
    logic unused_hi;
    assign unused_hi  = ^target[31:2];
    assign misaligned = |target[1:0];
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: +4 stepping in place, jumps through the external clocked offset adder.
// Alignment rule selected by RVC_ALIGN_EN (see target_align_check).
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a request; SEQ/not-taken done here
// ST_WAIT | operands on add_a/add_b, adder capturing sum
// ST_LOAD | add_sum valid; check alignment, load pc/fault
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_taken,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_base,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic [31:0] pc,
    output logic [31:0] link,
    output logic        done,
    output logic        fault,
    output logic [31:0] fault_addr
);

    state_e      state, state_next;
    op_e         op;
    logic        accept;
    logic        is_jump;
    logic        is_jalr;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        misaligned;

    assign op        = op_e'(req_op);
    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign pc_inc    = pc + 32'd4;
    assign is_jump   = ((op == OP_BRANCH) && req_taken) || (op == OP_JAL) || (op == OP_JALR);
    assign target    = is_jalr ? {add_sum[31:1], 1'b0} : add_sum;

    target_align_check u_align (
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_jump) state_next = ST_WAIT;
            ST_WAIT: state_next = ST_LOAD;
            ST_LOAD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            link       <= 32'd0;
            add_a      <= 32'd0;
            add_b      <= 32'd0;
            is_jalr    <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= 32'd0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        link <= pc_inc;
                        if (is_jump) begin
                            add_a   <= (op == OP_JALR) ? req_base : pc;
                            add_b   <= req_offset;
                            is_jalr <= (op == OP_JALR);
                        end else begin
                            pc   <= pc_inc;
                            done <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    done <= 1'b1;
                    if (misaligned) begin
                        fault      <= 1'b1;
                        fault_addr <= target;
                    end else begin
                        pc <= target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with a behavioural clocked offset adder.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        req_taken = 1'b0;
    logic [31:0] req_offset = 32'd0;
    logic [31:0] req_base = 32'd0;
    logic [31:0] add_a, add_b;
    logic [31:0] add_sum = 32'd0;
    logic [31:0] pc, link, fault_addr;
    logic        done, fault;

    int n_cmp = 0;
    int n_err = 0;

`ifdef RVC_ALIGN_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif
    localparam logic [31:0] PJ = RVC ? 32'h0000_1006 : 32'h0000_0200;

    pc_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_taken  (req_taken),
        .req_offset (req_offset),
        .req_base   (req_base),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .pc         (pc),
        .link       (link),
        .done       (done),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    // upstream clocked offset adder
    always @(posedge clk) add_sum <= add_a + add_b;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic        taken;
        logic [31:0] off;
        logic [31:0] base;
        logic [31:0] e_pc;
        logic [31:0] e_link;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_done;
        logic        e_fault;
        logic        e_ready;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t v(logic vl, logic [1:0] op, logic tk, logic [31:0] off, logic [31:0] base,
                               logic [31:0] p, logic [31:0] l, logic [31:0] a, logic [31:0] b,
                               logic d, logic f, logic r, logic [31:0] fa);
        vec_t t;
        t.valid = vl; t.op = op; t.taken = tk; t.off = off; t.base = base;
        t.e_pc = p; t.e_link = l; t.e_a = a; t.e_b = b;
        t.e_done = d; t.e_fault = f; t.e_ready = r; t.e_faddr = fa;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vl, input logic [1:0] op, input logic tk,
                         input logic [31:0] off, input logic [31:0] base);
        req_valid = vl; req_op = op; req_taken = tk; req_offset = off; req_base = base;
    endtask

    initial begin
        vecs[0]  = v(1, 0, 0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0, 1, 0, 1, 32'h0);
        vecs[1]  = v(1, 0, 0, 32'h0, 32'h0, 32'h8, 32'h8, 32'h0, 32'h0, 1, 0, 1, 32'h0);
        vecs[2]  = v(1, 0, 0, 32'h0, 32'h0, 32'hC, 32'hC, 32'h0, 32'h0, 1, 0, 1, 32'h0);
        vecs[3]  = v(1, 2, 0, 32'hF4, 32'h0, 32'hC, 32'h10, 32'hC, 32'hF4, 0, 0, 0, 32'h0);
        vecs[4]  = v(0, 0, 0, 32'h0, 32'h0, 32'hC, 32'h10, 32'hC, 32'hF4, 0, 0, 0, 32'h0);
        vecs[5]  = v(0, 0, 0, 32'h0, 32'h0, 32'h100, 32'h10, 32'hC, 32'hF4, 1, 0, 1, 32'h0);
        vecs[6]  = v(1, 1, 1, 32'hFFFF_FFF0, 32'h0, 32'h100, 32'h104, 32'h100, 32'hFFFF_FFF0, 0, 0, 0, 32'h0);
        vecs[7]  = v(0, 0, 0, 32'h0, 32'h0, 32'h100, 32'h104, 32'h100, 32'hFFFF_FFF0, 0, 0, 0, 32'h0);
        vecs[8]  = v(0, 0, 0, 32'h0, 32'h0, 32'hF0, 32'h104, 32'h100, 32'hFFFF_FFF0, 1, 0, 1, 32'h0);
        vecs[9]  = v(1, 1, 0, 32'h40, 32'h0, 32'hF4, 32'hF4, 32'h100, 32'hFFFF_FFF0, 1, 0, 1, 32'h0);
        vecs[10] = v(0, 0, 0, 32'h0, 32'h0, 32'hF4, 32'hF4, 32'h100, 32'hFFFF_FFF0, 0, 0, 1, 32'h0);
        vecs[11] = v(1, 2, 0, 32'h10C, 32'h0, 32'hF4, 32'hF8, 32'hF4, 32'h10C, 0, 0, 0, 32'h0);
        vecs[12] = v(0, 0, 0, 32'h0, 32'h0, 32'hF4, 32'hF8, 32'hF4, 32'h10C, 0, 0, 0, 32'h0);
        vecs[13] = v(0, 0, 0, 32'h0, 32'h0, 32'h200, 32'hF8, 32'hF4, 32'h10C, 1, 0, 1, 32'h0);
        vecs[14] = v(1, 3, 0, 32'h4, 32'h1003, 32'h200, 32'h204, 32'h1003, 32'h4, 0, 0, 0, 32'h0);
        vecs[15] = v(0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h204, 32'h1003, 32'h4, 0, 0, 0, 32'h0);
        vecs[16] = v(0, 0, 0, 32'h0, 32'h0, PJ, 32'h204, 32'h1003, 32'h4, 1, !RVC, 1, 32'h1006);
        vecs[17] = v(0, 0, 0, 32'h0, 32'h0, PJ, 32'h204, 32'h1003, 32'h4, 0, 0, 1, 32'h0);
        vecs[18] = v(1, 3, 0, 32'h4, 32'hFFFF_FFF8, PJ, PJ + 32'h4, 32'hFFFF_FFF8, 32'h4, 0, 0, 0, 32'h0);
        vecs[19] = v(0, 0, 0, 32'h0, 32'h0, PJ, PJ + 32'h4, 32'hFFFF_FFF8, 32'h4, 0, 0, 0, 32'h0);
        vecs[20] = v(0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, PJ + 32'h4, 32'hFFFF_FFF8, 32'h4, 1, 0, 1, 32'h0);
        vecs[21] = v(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h4, 1, 0, 1, 32'h0);
        vecs[22] = v(1, 1, 0, 32'h0, 32'h0, 32'h4, 32'h4, 32'hFFFF_FFF8, 32'h4, 1, 0, 1, 32'h0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst pc", pc, 32'h0);
        chk("rst link", link, 32'h0);
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst add_a", add_a, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].taken, vecs[i].off, vecs[i].base);
            @(negedge clk);
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d link", i), link, vecs[i].e_link);
            chk($sformatf("v%0d add_a", i), add_a, vecs[i].e_a);
            chk($sformatf("v%0d add_b", i), add_b, vecs[i].e_b);
            chk($sformatf("v%0d done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
            chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].e_fault});
            chk($sformatf("v%0d ready", i), {31'd0, req_ready}, {31'd0, vecs[i].e_ready});
            if (vecs[i].e_fault)
                chk($sformatf("v%0d fault_addr", i), fault_addr, vecs[i].e_faddr);
        end

        // reset asserted mid-WAIT discards the jump (pc=4 here)
        drive(1, 2, 0, 32'h20, 32'h0);
        @(negedge clk);
        chk("wait ready", {31'd0, req_ready}, 32'd0);
        drive(0, 0, 0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("midrst pc", pc, 32'h0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst ready", {31'd0, req_ready}, 32'd1);
        chk("midrst link", link, 32'h0);
        chk("midrst add_b", add_b, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst pc", pc, 32'h0);
        chk("postrst done", {31'd0, done}, 32'd0);
        drive(1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("postrst seq pc", pc, 32'h4);
        chk("postrst seq done", {31'd0, done}, 32'd1);

        // req_valid held through a JAL: next request taken only in the done cycle
        drive(1, 2, 0, 32'h8, 32'h0);
        @(negedge clk);
        chk("b2b E0 ready", {31'd0, req_ready}, 32'd0);
        chk("b2b E0 pc", pc, 32'h4);
        @(negedge clk);
        chk("b2b E1 ready", {31'd0, req_ready}, 32'd0);
        chk("b2b E1 pc", pc, 32'h4);
        chk("b2b E1 done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("b2b E2 pc", pc, 32'hC);
        chk("b2b E2 done", {31'd0, done}, 32'd1);
        chk("b2b E2 ready", {31'd0, req_ready}, 32'd1);
        drive(1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b E3 pc", pc, 32'h10);
        chk("b2b E3 link", link, 32'h10);
        chk("b2b E3 done", {31'd0, done}, 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b E4 done", {31'd0, done}, 32'd0);
        chk("b2b E4 pc", pc, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
